// File: rtl/morph_filter_if.sv
// Binary pixel-stream handshake for morph_filter: raster input side and filtered output side.
interface morph_filter_if;
   logic in_valid, in_sof, in_pix, mode;
   logic out_valid, out_sof, out_pix, frame_err;

   modport master (output in_valid, in_sof, in_pix, mode,
                   input  out_valid, out_sof, out_pix, frame_err);
   modport slave  (input  in_valid, in_sof, in_pix, mode,
                   output out_valid, out_sof, out_pix, frame_err);
endinterface

// File: rtl/morph_filter.sv
// Streaming binary erosion/dilation over a WIN_SIZE x WIN_SIZE window with a programmable
// structuring element; one registered output per accepted input once the window is primed.
module morph_filter #(
   parameter int H_IMG_RES = 640,
   parameter int V_IMG_RES = 480,
   parameter int WIN_SIZE  = 5,
   parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'b01110_11111_11111_11111_01110
) (
   input  logic      clk,
   input  logic      rst,
   morph_filter_if.slave s
);
   localparam int W  = WIN_SIZE;
   localparam int R  = WIN_SIZE / 2;
   localparam int CW = (H_IMG_RES > 1) ? $clog2(H_IMG_RES) : 1;
   localparam int RW = (V_IMG_RES > 1) ? $clog2(V_IMG_RES) : 1;

   logic [CW-1:0] col, pc, col_n;
   logic [RW-1:0] row, pr, row_n;
   logic          started, primed, mode_lat, mode_act;
   logic          acc, at_org, err_n, o00, border, ero, dil, mode_use;
   logic          ov, os, op, fe;
   int            ocol, orow;

   // lb[0] is the previous line, lb[k] the line k+1 rows back
   logic [W-2:0][H_IMG_RES-1:0] lb;
   // win[0] is the oldest (top) row, win[i][0] the leftmost column
   logic [W-1:0][W-1:0]         win, win_n;
   logic [W-1:0]                new_col;

   assign acc    = s.in_valid & (started | s.in_sof);
   assign pc     = s.in_sof ? '0 : col;
   assign pr     = s.in_sof ? '0 : row;
   assign at_org = (col == '0) && (row == '0);
   assign err_n  = acc & started & (s.in_sof ? ~at_org : at_org);

   always_comb begin
      col_n = pc + 1'b1;
      row_n = pr;
      if (pc == CW'(H_IMG_RES-1)) begin
         col_n = '0;
         row_n = (pr == RW'(V_IMG_RES-1)) ? '0 : pr + 1'b1;
      end
   end

   always_comb begin
      new_col        = '0;
      new_col[W-1]   = s.in_pix;
      for (int k = 0; k < W-1; k++) new_col[W-2-k] = lb[k][pc];
      win_n = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W-1; j++) win_n[i][j] = win[i][j+1];
         win_n[i][W-1] = new_col[i];
      end
   end

   // The accepted pixel is the bottom-right of the window centred R lines and R columns back
   always_comb begin
      ocol = int'(pc) - R;
      orow = int'(pr) - R;
      if (ocol < 0) begin
         ocol = ocol + H_IMG_RES;
         orow = orow - 1;
      end
      if (orow < 0) orow = orow + V_IMG_RES;
      o00    = (ocol == 0) && (orow == 0);
      border = (orow < R) || (orow > V_IMG_RES-1-R) || (ocol < R) || (ocol > H_IMG_RES-1-R);
      mode_use = o00 ? mode_lat : mode_act;
   end

   always_comb begin
      ero = 1'b1;
      dil = 1'b0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < W; j++)
            if (STRUCT_ELM[W*W-1-(i*W+j)]) begin
               ero = ero & win_n[i][j];
               dil = dil | win_n[i][j];
            end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col      <= '0;
         row      <= '0;
         started  <= 1'b0;
         primed   <= 1'b0;
         mode_lat <= 1'b0;
         mode_act <= 1'b0;
         ov       <= 1'b0;
         os       <= 1'b0;
         op       <= 1'b0;
         fe       <= 1'b0;
      end else begin
         ov <= acc & (primed | o00);
         os <= acc & o00;
         op <= acc & (primed | o00) & ~border & (mode_use ? dil : ero);
         fe <= err_n;
         if (acc) begin
            col     <= col_n;
            row     <= row_n;
            started <= 1'b1;
            if (s.in_sof) mode_lat <= s.mode;
            // the frame's mode takes over exactly when its output (0,0) is produced
            if (o00) begin
               primed   <= 1'b1;
               mode_act <= mode_lat;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         win      <= win_n;
         lb[0][pc] <= s.in_pix;
         for (int k = 1; k < W-1; k++) lb[k][pc] <= lb[k-1][pc];
      end
   end

   assign s.out_valid = ov;
   assign s.out_sof   = os;
   assign s.out_pix   = op;
   assign s.frame_err = fe;
endmodule

// File: tb/tb_morph_filter.sv
// Scoreboard bench for morph_filter: two instances (full 3x3 and cross SE) on one stimulus stream,
// checked against a frame-level reference computed from whole images.
module tb_morph_filter;
   localparam int H = 8, V = 6, W = 3, R = 1, N = H*V;
   localparam logic [8:0] SE_A = 9'b111_111_111;
   localparam logic [8:0] SE_B = 9'b010_111_010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   morph_filter_if ifa();
   morph_filter_if ifb();

   morph_filter #(.H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(W), .STRUCT_ELM(SE_A))
      dut_a (.clk(clk), .rst(rst), .s(ifa));
   morph_filter #(.H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(W), .STRUCT_ELM(SE_B))
      dut_b (.clk(clk), .rst(rst), .s(ifb));

   int n_chk = 0, n_pass = 0, err_a = 0, err_b = 0, gap_mode = 0;
   bit [1:0] q_a[$], q_b[$];
   bit img[V][H];
   logic acc_q = 1'b0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic bit rb();
      return bit'($urandom & 1);
   endfunction

   function automatic int gapn();
      case (gap_mode)
         0: return 0;
         1: return 1;
         default: return int'($urandom_range(2));
      endcase
   endfunction

   // Reference: erosion/dilation of the stored image, border forced to 0
   function automatic bit ref_px(int r, int c, bit md, logic [8:0] se);
      bit all1 = 1'b1, any1 = 1'b0;
      if (r < R || r > V-1-R || c < R || c > H-1-R) return 1'b0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if (se[8-((dr+1)*3+(dc+1))]) begin
               all1 &= img[r+dr][c+dc];
               any1 |= img[r+dr][c+dc];
            end
      return md ? any1 : all1;
   endfunction

   task automatic mkimg(int kind);
      for (int r = 0; r < V; r++)
         for (int c = 0; c < H; c++)
            case (kind)
               0: img[r][c] = 1'b1;
               1: img[r][c] = rb();
               default: img[r][c] = (r == 3 && c == 3);
            endcase
   endtask

   task automatic push_frame(bit md, int npos);
      for (int p = 0; p < npos; p++) begin
         q_a.push_back({p == 0, ref_px(p/H, p%H, md, SE_A)});
         q_b.push_back({p == 0, ref_px(p/H, p%H, md, SE_B)});
      end
   endtask

   task automatic push_tail();
      repeat (R*H+R) begin
         q_a.push_back(2'b00);
         q_b.push_back(2'b00);
      end
   endtask

   task automatic set_in(bit v, bit sf, bit px, bit md);
      ifa.in_valid = v; ifa.in_sof = sf; ifa.in_pix = px; ifa.mode = md;
      ifb.in_valid = v; ifb.in_sof = sf; ifb.in_pix = px; ifb.mode = md;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(bit sf, bit px, bit md, int gap);
      repeat (gap) begin
         set_in(1'b0, rb(), rb(), rb());
         cyc();
      end
      set_in(1'b1, sf, px, md);
      cyc();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_frame(bit md, bit with_sof, int sw, int p0, int p1);
      for (int p = p0; p < p1; p++) begin
         bit m;
         if (p == 0 && with_sof) m = md;
         else if (sw >= 0)       m = (p >= sw) ? ~md : md;
         else                    m = rb();
         send(with_sof && p == 0, img[p/H][p%H], m, gapn());
      end
   endtask

   task automatic flush(int exp_err);
      for (int p = 0; p < R*H+R; p++) send(p == 0, rb(), rb(), gapn());
      repeat (3) cyc();
      chk("q_empty_a", q_a.size(), 0);
      chk("q_empty_b", q_b.size(), 0);
      chk("err_cnt_a", err_a, exp_err);
      chk("err_cnt_b", err_b, exp_err);
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         set_in(1'b1, rb(), rb(), rb());
         cyc();
         chk("rst_out", int'({ifa.out_valid, ifa.out_sof, ifa.out_pix, ifa.frame_err,
                              ifb.out_valid, ifb.out_sof, ifb.out_pix, ifb.frame_err}), 0);
      end
      chk("rst_q_drain", q_a.size() + q_b.size(), 0);
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      q_a.delete(); q_b.delete();
      err_a = 0; err_b = 0;
   endtask

   always @(posedge clk) acc_q <= ifa.in_valid;

   always @(negedge clk) begin : mon_a
      bit [1:0] e;
      if (ifa.frame_err) err_a++;
      if (ifa.out_valid) begin
         chk("gap_a", int'(acc_q), 1);
         if (q_a.size() == 0) begin
            n_chk++;
            $display("FAIL extra_a: got out_valid=1 want no output (queue empty) at %0t", $time);
         end else begin
            e = q_a.pop_front();
            chk("pix_a", int'(ifa.out_pix), int'(e[0]));
            chk("sof_a", int'(ifa.out_sof), int'(e[1]));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      bit [1:0] e;
      if (ifb.frame_err) err_b++;
      if (ifb.out_valid) begin
         chk("gap_b", int'(acc_q), 1);
         if (q_b.size() == 0) begin
            n_chk++;
            $display("FAIL extra_b: got out_valid=1 want no output (queue empty) at %0t", $time);
         end else begin
            e = q_b.pop_front();
            chk("pix_b", int'(ifb.out_pix), int'(e[0]));
            chk("sof_b", int'(ifb.out_sof), int'(e[1]));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      // reset held with in_valid high
      do_reset(3);

      // junk before first sof, then two all-ones erosion frames
      repeat (5) send(1'b0, rb(), rb(), 0);
      gap_mode = 0;
      mkimg(0);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, -1, 0, N);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, -1, 0, N);
      flush(0);

      // single set pixel, dilation
      do_reset(2);
      mkimg(2);
      push_frame(1'b1, N); run_frame(1'b1, 1'b1, -1, 0, N);
      flush(0);

      // all-ones erosion with in_valid toggling
      do_reset(2);
      gap_mode = 1;
      mkimg(0);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, -1, 0, N);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, -1, 0, N);
      flush(0);

      // random images, random modes, random gaps
      do_reset(2);
      gap_mode = 2;
      for (int f = 0; f < 3; f++) begin
         bit md = rb();
         mkimg(1);
         push_frame(md, N); run_frame(md, 1'b1, -1, 0, N);
      end
      flush(0);

      // mode raised at (2,5) of frame 1 only affects frame 2
      do_reset(2);
      gap_mode = 0;
      mkimg(1);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, 2*H+5, 0, N);
      mkimg(1);
      push_frame(1'b1, N); run_frame(1'b1, 1'b1, -1, 0, N);
      flush(0);

      // early sof at index 20, then a correct frame, then a frame missing its sof
      do_reset(2);
      mkimg(0);
      push_frame(1'b0, 20-(R*H+R)); push_tail();
      run_frame(1'b0, 1'b1, -1, 0, 20);
      push_frame(1'b0, N);
      send(1'b1, 1'b1, 1'b0, 0);
      chk("err_pulse_a", int'(ifa.frame_err), 1);
      chk("err_pulse_b", int'(ifb.frame_err), 1);
      send(1'b0, img[0][1], rb(), 0);
      chk("err_width_a", int'(ifa.frame_err), 0);
      run_frame(1'b0, 1'b1, -1, 2, N);
      push_frame(1'b0, N); run_frame(1'b0, 1'b1, -1, 0, N);
      chk("err_aligned", err_a, 1);
      push_frame(1'b0, N); run_frame(1'b0, 1'b0, -1, 0, N);
      flush(2);

      // reset in the middle of a frame, then a clean frame
      do_reset(2);
      gap_mode = 2;
      begin
         bit md = rb();
         mkimg(1);
         push_frame(md, 15-(R*H+R)); run_frame(md, 1'b1, -1, 0, 15);
      end
      do_reset(2);
      begin
         bit md = rb();
         mkimg(1);
         push_frame(md, N); run_frame(md, 1'b1, -1, 0, N);
      end
      flush(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
